// File: rtl/board_arb_if.sv
// Board arbiter bus: vga scanner, game logic and host ports plus the board RAM port.
// The arbiter side uses the slave modport; requesters and RAM use master.
interface board_arb_if #(
    parameter int unsigned X_W = 6,
    parameter int unsigned Y_W = 5
);
    localparam int unsigned A = X_W + Y_W;

    logic           vga_req;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic           vga_valid;
    logic           vga_data;

    logic           game_req;
    logic           game_we;
    logic [X_W-1:0] game_x;
    logic [Y_W-1:0] game_y;
    logic           game_wdata;
    logic           game_ack;
    logic           game_rvalid;
    logic           game_rdata;

    logic           host_req;
    logic           host_we;
    logic [A-1:0]   host_addr;
    logic           host_wdata;
    logic           host_ack;
    logic           host_rvalid;
    logic           host_rdata;

    logic [A-1:0]   ram_addr;
    logic           ram_we;
    logic           ram_wdata;
    logic           ram_rdata;

    logic           ready;

    modport slave (
        input  vga_req, vga_x, vga_y,
        output vga_valid, vga_data,
        input  game_req, game_we, game_x, game_y, game_wdata,
        output game_ack, game_rvalid, game_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rvalid, host_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output ready
    );

    modport master (
        output vga_req, vga_x, vga_y,
        input  vga_valid, vga_data,
        output game_req, game_we, game_x, game_y, game_wdata,
        input  game_ack, game_rvalid, game_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rvalid, host_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  ready
    );
endinterface

// File: rtl/board_arb.sv
// Single-port board RAM arbiter: vga > round-robin(game, host), one access per cycle.
// Define CLEAR_ON_RESET_EN to zero the whole board after reset before accepting requests.
module board_arb #(
    parameter int unsigned X_W = 6,
    parameter int unsigned Y_W = 5
) (
    input logic       clk,
    input logic       rst,
    board_arb_if.slave bus
);
    localparam int unsigned A = X_W + Y_W;

    logic         run;
    logic         clearing;
    logic [A-1:0] clr_addr;

`ifdef CLEAR_ON_RESET_EN
    typedef enum logic {StClear, StRun} state_e;

    state_e       state;
    logic [A-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StClear;
            clr_cnt <= '0;
        end else if (state == StClear) begin
            if (clr_cnt == {A{1'b1}}) begin
                state <= StRun;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    assign run      = (state == StRun) && !rst;
    assign clearing = (state == StClear) && !rst;
    assign clr_addr = clr_cnt;
`else
    assign run      = !rst;
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    logic         rr_pref;
    logic         game_rvalid_q;
    logic         host_rvalid_q;
    logic         vga_valid_q;
    logic         vga_rd_q;
    logic [A-1:0] addr_q;
    logic         vga_g;
    logic         game_g;
    logic         host_g;
    logic         conflict;

    assign conflict = bus.game_req && bus.host_req;
    assign vga_g    = run && bus.vga_req;
    assign game_g   = run && !bus.vga_req && bus.game_req && (!bus.host_req || !rr_pref);
    assign host_g   = run && !bus.vga_req && bus.host_req && (!bus.game_req || rr_pref);

    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_wdata = 1'b0;
        bus.ram_addr  = addr_q;
        if (rst) begin
            bus.ram_addr = '0;
        end else if (clearing) begin
            bus.ram_addr = clr_addr;
            bus.ram_we   = 1'b1;
        end else if (vga_g) begin
            bus.ram_addr = {bus.vga_y, bus.vga_x};
        end else if (game_g) begin
            bus.ram_addr  = {bus.game_y, bus.game_x};
            bus.ram_we    = bus.game_we;
            bus.ram_wdata = bus.game_we && bus.game_wdata;
        end else if (host_g) begin
            bus.ram_addr  = bus.host_addr;
            bus.ram_we    = bus.host_we;
            bus.ram_wdata = bus.host_we && bus.host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_pref       <= 1'b0;
            game_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            vga_valid_q   <= 1'b0;
            vga_rd_q      <= 1'b0;
            addr_q        <= '0;
        end else begin
            if (conflict && (game_g || host_g)) begin
                rr_pref <= !rr_pref;
            end
            game_rvalid_q <= game_g && !bus.game_we;
            host_rvalid_q <= host_g && !bus.host_we;
            // A vga read during clearing is answered with zero, without touching the RAM.
            vga_valid_q   <= bus.vga_req;
            vga_rd_q      <= vga_g;
            addr_q        <= bus.ram_addr;
        end
    end

    // Reset masks the registered returns too, so a read in flight never surfaces.
    assign bus.game_ack    = game_g;
    assign bus.host_ack    = host_g;
    assign bus.game_rvalid = game_rvalid_q && !rst;
    assign bus.host_rvalid = host_rvalid_q && !rst;
    assign bus.game_rdata  = bus.game_rvalid && bus.ram_rdata;
    assign bus.host_rdata  = bus.host_rvalid && bus.ram_rdata;
    assign bus.vga_valid   = vga_valid_q && !rst;
    assign bus.vga_data    = vga_rd_q && !rst && bus.ram_rdata;
    assign bus.ready       = run;
endmodule

// File: tb/tb_board_arb.sv
// Directed bench for board_arb with a 1-cycle synchronous RAM model.
// Build with CLEAR_ON_RESET_EN defined to also exercise the clear sequence.
module tb_board_arb;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    bit   mem [0:2047];

    board_arb_if #(.X_W(6), .Y_W(5)) bus ();

    board_arb #(.X_W(6), .Y_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", bus.ram_we); end
        n_cmp++; if (bus.ram_addr !== 11'h0) begin n_err++; $display("FAIL rst_addr: got %h want 000", bus.ram_addr); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
`ifdef CLEAR_ON_RESET_EN
        n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL post_rst_ready: got %b want 0", bus.ready); end
`else
        n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", bus.ready); end
`endif
        @(posedge clk); #1;
    endtask

`ifdef CLEAR_ON_RESET_EN
    task automatic test_clear();
        int bad;
        bad = 0;
        rst = 1'b1; bus.game_req = 1'b1; bus.game_we = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            if (bus.ram_addr !== 11'(i) || bus.ram_we !== 1'b1 || bus.ram_wdata !== 1'b0 ||
                bus.ready !== 1'b0 || bus.game_ack !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            bus.vga_req = (i == 5);
            @(negedge clk);
            if (bus.ram_addr !== 11'(i) || bus.ram_we !== 1'b1 || bus.ram_wdata !== 1'b0 ||
                bus.ready !== 1'b0 || bus.game_ack !== 1'b0) bad++;
            if (i == 6 && (bus.vga_valid !== 1'b1 || bus.vga_data !== 1'b0)) bad++;
            @(posedge clk); #1;
        end
        bus.vga_req = 1'b0;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL clear_seq: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL clear_done_ready: got %b want 1", bus.ready); end
        n_cmp++; if (bus.game_ack !== 1'b1) begin n_err++; $display("FAIL clear_done_ack: got %b want 1", bus.game_ack); end
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL clear_done_we: got %b want 0", bus.ram_we); end
        @(posedge clk); #1 bus.game_req = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_host_write_read();
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 11'h7FF; bus.host_wdata = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.host_ack !== 1'b1) begin n_err++; $display("FAIL hw_ack: got %b want 1", bus.host_ack); end
        n_cmp++; if (bus.ram_we !== 1'b1) begin n_err++; $display("FAIL hw_we: got %b want 1", bus.ram_we); end
        n_cmp++; if (bus.ram_addr !== 11'h7FF) begin n_err++; $display("FAIL hw_addr: got %h want 7ff", bus.ram_addr); end
        n_cmp++; if (bus.ram_wdata !== 1'b1) begin n_err++; $display("FAIL hw_wdata: got %b want 1", bus.ram_wdata); end
        @(posedge clk); #1 bus.host_we = 1'b0; bus.host_wdata = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.host_rvalid !== 1'b0) begin n_err++; $display("FAIL hw_no_rvalid: got %b want 0", bus.host_rvalid); end
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL hr_we: got %b want 0", bus.ram_we); end
        @(posedge clk); #1 bus.host_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.host_rvalid !== 1'b1) begin n_err++; $display("FAIL hr_rvalid: got %b want 1", bus.host_rvalid); end
        n_cmp++; if (bus.host_rdata !== 1'b1) begin n_err++; $display("FAIL hr_rdata: got %b want 1", bus.host_rdata); end
        // Preload cells used later: (3,2) = 0x083 and (1,3) = 0x0C1.
        @(posedge clk); #1 bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_wdata = 1'b1; bus.host_addr = 11'h083;
        @(negedge clk);
        n_cmp++; if (bus.host_rvalid !== 1'b0) begin n_err++; $display("FAIL hr_one_cycle: got %b want 0", bus.host_rvalid); end
        @(posedge clk); #1 bus.host_addr = 11'h0C1;
        @(posedge clk); #1 bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_wdata = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_game_read();
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_x = 6'd3; bus.game_y = 5'd2;
        @(negedge clk);
        n_cmp++; if (bus.game_ack !== 1'b1) begin n_err++; $display("FAIL gr_ack: got %b want 1", bus.game_ack); end
        n_cmp++; if (bus.ram_addr !== 11'h083) begin n_err++; $display("FAIL gr_addr: got %h want 083", bus.ram_addr); end
        @(posedge clk); #1 bus.game_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.game_rvalid !== 1'b1) begin n_err++; $display("FAIL gr_rvalid: got %b want 1", bus.game_rvalid); end
        n_cmp++; if (bus.game_rdata !== 1'b1) begin n_err++; $display("FAIL gr_rdata: got %b want 1", bus.game_rdata); end
        n_cmp++; if (bus.host_rvalid !== 1'b0) begin n_err++; $display("FAIL gr_host_rvalid: got %b want 0", bus.host_rvalid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.game_rvalid !== 1'b0) begin n_err++; $display("FAIL gr_one_cycle: got %b want 0", bus.game_rvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_vga_priority();
        logic [5:0]  vx [3];
        logic [4:0]  vy [3];
        logic        vd [3];
        logic [10:0] va;
        vx = '{6'd3, 6'd1, 6'd0}; vy = '{5'd2, 5'd3, 5'd0}; vd = '{1'b1, 1'b1, 1'b0};
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_x = 6'd5; bus.game_y = 5'd5;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 11'h100;
        for (int c = 0; c < 3; c++) begin
            bus.vga_req = 1'b1; bus.vga_x = vx[c]; bus.vga_y = vy[c];
            va = {vy[c], vx[c]};
            @(negedge clk);
            n_cmp++; if (bus.ram_addr !== va) begin n_err++; $display("FAIL vga_addr%0d: got %h want %h", c, bus.ram_addr, va); end
            n_cmp++; if ({bus.game_ack, bus.host_ack} !== 2'b00) begin n_err++; $display("FAIL vga_acks%0d: got %b want 00", c, {bus.game_ack, bus.host_ack}); end
            if (c > 0) begin
                n_cmp++; if (bus.vga_valid !== 1'b1 || bus.vga_data !== vd[c-1]) begin n_err++; $display("FAIL vga_ret%0d: got %b/%b want 1/%b", c, bus.vga_valid, bus.vga_data, vd[c-1]); end
            end
            @(posedge clk); #1;
        end
        bus.vga_req = 1'b0; bus.game_req = 1'b0; bus.host_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.vga_valid !== 1'b1 || bus.vga_data !== 1'b0) begin n_err++; $display("FAIL vga_last: got %b/%b want 1/0", bus.vga_valid, bus.vga_data); end
        n_cmp++; if ({bus.game_rvalid, bus.host_rvalid} !== 2'b00) begin n_err++; $display("FAIL vga_no_rv: got %b want 00", {bus.game_rvalid, bus.host_rvalid}); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.vga_valid !== 1'b0) begin n_err++; $display("FAIL vga_idle: got %b want 0", bus.vga_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp [4];
        exp = '{2'b10, 2'b01, 2'b10, 2'b01};
        bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_wdata = 1'b0; bus.game_x = 6'd10; bus.game_y = 5'd1;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_wdata = 1'b0; bus.host_addr = 11'h200;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if ({bus.game_ack, bus.host_ack} !== exp[c]) begin n_err++; $display("FAIL rr_ack%0d: got %b want %b", c, {bus.game_ack, bus.host_ack}, exp[c]); end
            @(posedge clk); #1;
        end
        bus.game_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.host_ack !== 1'b1) begin n_err++; $display("FAIL rr_lone: got %b want 1", bus.host_ack); end
        @(posedge clk); #1 bus.game_req = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.game_ack, bus.host_ack} !== 2'b10) begin n_err++; $display("FAIL rr_keep_pref: got %b want 10", {bus.game_ack, bus.host_ack}); end
        @(posedge clk); #1 bus.game_req = 1'b0; bus.host_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 11'h04A) begin n_err++; $display("FAIL idle_hold%0d: got we=%b addr=%h want we=0 addr=04a", c, bus.ram_we, bus.ram_addr); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_read();
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_x = 6'd3; bus.game_y = 5'd2;
        @(negedge clk);
        n_cmp++; if (bus.game_ack !== 1'b1) begin n_err++; $display("FAIL rmr_ack: got %b want 1", bus.game_ack); end
        @(posedge clk); #1 rst = 1'b1; bus.game_req = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.game_rvalid, bus.game_rdata, bus.vga_valid, bus.ram_we, bus.ready} !== 5'b0) begin n_err++; $display("FAIL rmr_outs: got %b want 00000", {bus.game_rvalid, bus.game_rdata, bus.vga_valid, bus.ram_we, bus.ready}); end
        n_cmp++; if (bus.ram_addr !== 11'h0) begin n_err++; $display("FAIL rmr_addr: got %h want 000", bus.ram_addr); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.game_rvalid !== 1'b0) begin n_err++; $display("FAIL rmr_no_rvalid: got %b want 0", bus.game_rvalid); end
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        bus.vga_req = 1'b0; bus.vga_x = '0; bus.vga_y = '0;
        bus.game_req = 1'b0; bus.game_we = 1'b0; bus.game_x = '0; bus.game_y = '0; bus.game_wdata = 1'b0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = 1'b0;
        test_reset();
`ifdef CLEAR_ON_RESET_EN
        test_clear();
`endif
        test_host_write_read();
        test_game_read();
        test_vga_priority();
        test_round_robin();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/board_arb.md
BOARD_ARB -- requirements
Module: board_arb

Interface
REQ-001 SHALL have parameter X_W, default 6, board column address width.
REQ-002 SHALL have parameter Y_W, default 5, board row address width; board cells = 2^(X_W+Y_W), 1 bit each.
REQ-003 SHALL have ports (A = X_W+Y_W):
- clk  in  1  sole clock, vclk domain, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- vga_req  in  1  single-cycle read request from the display scanner.
- vga_x  in  X_W  / vga_y  in  Y_W  cell address for vga_req.
- vga_valid  out  1  pulse: vga_data valid.
- vga_data  out  1  cell value for the vga read.
- game_req  in  1  game-logic access request, held until ack.
- game_we  in  1  1 = write, 0 = read.
- game_x  in  X_W  / game_y  in  Y_W  game cell address.
- game_wdata  in  1  game write data.
- game_ack  out  1  grant pulse for the game port.
- game_rvalid  out  1  / game_rdata  out  1  game read return.
- host_req  in  1  EPP-host access request, held until ack.
- host_we  in  1  1 = write.
- host_addr  in  A  linear cell address, {y, x}.
- host_wdata  in  1  host write data.
- host_ack  out  1  / host_rvalid  out  1  / host_rdata  out  1  host grant and read return.
- ram_addr  out  A  / ram_we  out  1  / ram_wdata  out  1  board RAM port.
- ram_rdata  in  1  RAM read data, 1-cycle synchronous latency.
- ready  out  1  high when the arbiter accepts requests (state RUN).

Function
REQ-004 SHALL have exactly one RAM access per cycle, granted combinationally from the current-cycle requests.
REQ-005 SHALL use priority vga > round-robin(game, host); vga_req always wins and is never stalled.
REQ-006 SHALL track a 1-bit rr_pref register (0 = game preferred); on a game/host conflict without vga, grant the preferred port and toggle rr_pref; a lone requester is granted without changing rr_pref.
REQ-007 SHALL drive game_ack/host_ack in the grant cycle N; the requester drops or changes req after sampling ack.
REQ-008 SHALL, for a read granted in cycle N, assert the port's rvalid and rdata = ram_rdata in cycle N+1, for exactly one cycle.
REQ-009 SHALL, for a write granted in cycle N, drive ram_we = 1 and ram_wdata in cycle N, with no rvalid.
REQ-010 SHALL form the RAM address as {y, x}; vga and game addresses are concatenated and the host address passes through.
REQ-011 SHALL, in cycles with no grant, drive ram_we = 0 and hold ram_addr at its previous value.
REQ-012 SHALL give game and host an ack within 2 cycles of req when vga_req is idle.
REQ-013 SHALL implement a state machine with states CLEAR and RUN; ready = 1 only in RUN.
REQ-014 SHALL, in CLEAR: step a counter 0..2^A-1 writing 0 to every cell (ram_we = 1); give no game/host acks; answer vga_req with vga_valid at N+1 and vga_data = 0; enter RUN after the last cell, with no wrap.

Reset
REQ-015 SHALL, with rst high at a clock edge, set all acks, rvalids, vga_valid, rdata, ram_we, ram_wdata, ram_addr and rr_pref to 0; this includes rst asserted mid-access or mid-CLEAR.
REQ-016 SHALL enter state CLEAR with counter = 0 if CLEAR_ON_RESET_EN is defined, otherwise RUN with ready = 1 in the first cycle after rst.
REQ-017 SHALL discard any read in flight when rst is asserted: no rvalid follows.

Configuration
REQ-018 SHALL, with CLEAR_ON_RESET_EN defined, compile in the CLEAR state and clear counter; the board is zeroed in 2^A cycles after reset.
REQ-019 SHALL, without CLEAR_ON_RESET_EN, omit the CLEAR state and counter; board contents are undefined after reset and ready is constant 1 outside reset.

Verification
REQ-020 SHALL cover: game read of (3,2) with RAM cell 0x083 = 1 -> game_ack at N, game_rvalid = 1 and game_rdata = 1 at N+1.
REQ-021 SHALL cover: vga_req, game_req and host_req all high for 3 cycles -> vga granted every cycle, game_ack = 0 and host_ack = 0 throughout.
REQ-022 SHALL cover: game_req and host_req held high continuously, rr_pref = 0 -> ack order game, host, game, host.
REQ-023 SHALL cover: host write addr 0x7FF, data 1, then a host read -> ram_we pulse at 0x7FF, then host_rdata = 1.
REQ-024 SHALL cover: CLEAR_ON_RESET_EN defined, rst released -> 2048 zero writes with ready = 0, game_req ignored, then ready = 1; rst reasserted at clear cycle 100 -> counter restarts at 0.
REQ-025 SHALL cover: rst asserted the cycle after a read grant -> no rvalid, all outputs 0.
